// File: rtl/spi_accel_poller.sv
// Autonomous spi0 register-port master: configures an ADXL345-style accelerometer, then polls X/Y/Z.
// Optional build macro ACCEL_POLL_DEVID_CHECK_EN adds a DEVID (reg 0x00 == 0xE5) check at the start of INIT.
module spi_accel_poller #(
  parameter int unsigned POLL_CYCLES = 1000000,
  parameter logic [7:0]  DATA_FORMAT = 8'h0B,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  output logic        spi_select_o,
  output logic        spi_read_n_o,
  output logic        spi_write_n_o,
  output logic [2:0]  spi_mem_addr_o,
  output logic [15:0] spi_wdata_o,
  input  logic [15:0] spi_rdata_i,
  output logic [15:0] accel_x_o,
  output logic [15:0] accel_y_o,
  output logic [15:0] accel_z_o,
  output logic        sample_valid_o,
  output logic        busy_o,
  output logic        error_o
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_BURST, S_RELEASE} state_e;
  typedef enum logic [1:0] {OP_WR, OP_XFER, OP_TMT} op_e;

`ifdef ACCEL_POLL_DEVID_CHECK_EN
  localparam logic [4:0] DEV = 5'd5;
`else
  localparam logic [4:0] DEV = 5'd0;
`endif
  localparam logic [4:0] INIT_LAST   = 5'd10 + DEV;
  localparam logic [4:0] BURST_FIRST = 5'd16;
  localparam logic [4:0] CAP_FIRST   = 5'd18;
  localparam logic [4:0] BURST_LAST  = 5'd25;
  localparam int unsigned CNT_W      = $clog2(POLL_CYCLES) + 1;
  localparam int unsigned POLL_W     = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_MAX    = POLL_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [4:0]        step_q, step_d;
  logic [1:0]        sub_q, sub_d, beat_q, beat_d;
  logic [POLL_W-1:0] polls_q, polls_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0][7:0]   cap_q, cap_d;
  logic              sel_q, sel_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [2:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d, ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic              sv_q, sv_d, busy_q, busy_d, err_q, err_d;

  op_e               op_s;
  logic [2:0]        tab_addr_s, acc_addr_s, cap_idx_s;
  logic [15:0]       tab_data_s, acc_data_s;
  logic              acc_rd_s, advance_s, abort_s;
  logic [7:0]        rx_byte_s;
  logic              unused_rdata_s;

  assign rx_byte_s      = spi_rdata_i[7:0];
  assign unused_rdata_s = ^{spi_rdata_i[15:8], spi_rdata_i[6], spi_rdata_i[2:0]};

  // State and output registers; async reset releases every strobe at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;  step_q <= 5'd0;  sub_q <= 2'd0;  beat_q <= 2'd0;
      polls_q <= '0;      cnt_q <= '0;     cap_q <= '0;
      sel_q <= 1'b0;      rd_n_q <= 1'b1;  wr_n_q <= 1'b1;
      addr_q <= 3'd0;     wdata_q <= 16'h0000;
      ax_q <= 16'h0000;   ay_q <= 16'h0000; az_q <= 16'h0000;
      sv_q <= 1'b0;       busy_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d; step_q <= step_d; sub_q <= sub_d;   beat_q <= beat_d;
      polls_q <= polls_d; cnt_q <= cnt_d;   cap_q <= cap_d;
      sel_q <= sel_d;     rd_n_q <= rd_n_d; wr_n_q <= wr_n_d;
      addr_q <= addr_d;   wdata_q <= wdata_d;
      ax_q <= ax_d;       ay_q <= ay_d;     az_q <= az_d;
      sv_q <= sv_d;       busy_q <= busy_d; err_q <= err_d;
    end
  end

  // Sequence table and decode of the bus access for the current step/sub-phase.
  always_comb begin
    op_s = OP_WR; tab_addr_s = 3'd3; tab_data_s = 16'h0000;
    case (step_q)
      5'd0:        begin op_s = OP_WR;   tab_addr_s = 3'd5; tab_data_s = 16'h0001; end
      5'd1:        begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0400; end
`ifdef ACCEL_POLL_DEVID_CHECK_EN
      5'd2:        begin op_s = OP_XFER; tab_data_s = 16'h0080; end
      5'd3:        begin op_s = OP_XFER; tab_data_s = 16'h0000; end
      5'd4:        begin op_s = OP_TMT;  end
      5'd5:        begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0000; end
      5'd6:        begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0400; end
`endif
      5'd2 + DEV:  begin op_s = OP_XFER; tab_data_s = 16'h0031; end
      5'd3 + DEV:  begin op_s = OP_XFER; tab_data_s = {8'h00, DATA_FORMAT}; end
      5'd4 + DEV:  begin op_s = OP_TMT;  end
      5'd5 + DEV:  begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0000; end
      5'd6 + DEV:  begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0400; end
      5'd7 + DEV:  begin op_s = OP_XFER; tab_data_s = 16'h002D; end
      5'd8 + DEV:  begin op_s = OP_XFER; tab_data_s = 16'h0008; end
      5'd9 + DEV:  begin op_s = OP_TMT;  end
      5'd10 + DEV: begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0000; end
      5'd16:       begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0400; end
      5'd17:       begin op_s = OP_XFER; tab_data_s = 16'h00F2; end
      5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23:
                   begin op_s = OP_XFER; tab_data_s = 16'h0000; end
      5'd24:       begin op_s = OP_TMT;  end
      default:     begin op_s = OP_WR;   tab_addr_s = 3'd3; tab_data_s = 16'h0000; end
    endcase

    acc_rd_s = 1'b0; acc_addr_s = tab_addr_s; acc_data_s = tab_data_s;
    cap_idx_s = 3'(step_q - CAP_FIRST);
    if (state_q == S_RELEASE) begin
      acc_addr_s = 3'd3; acc_data_s = 16'h0000;
    end else if (op_s == OP_TMT) begin
      acc_rd_s = 1'b1; acc_addr_s = 3'd2; acc_data_s = 16'h0000;
    end else if (op_s == OP_XFER) begin
      case (sub_q)
        2'd0:    begin acc_addr_s = 3'd1; acc_data_s = {8'h00, tab_data_s[7:0]}; end
        2'd1:    begin acc_rd_s = 1'b1; acc_addr_s = 3'd2; acc_data_s = 16'h0000; end
        default: begin acc_rd_s = 1'b1; acc_addr_s = 3'd0; acc_data_s = 16'h0000; end
      endcase
    end else begin
      acc_rd_s = 1'b0;
    end
  end

  // Next-state logic: beat 0 launches an access, beats 1-2 hold it, end of beat 2 samples rdata.
  always_comb begin
    state_d = state_q; step_d = step_q; sub_d = sub_q; beat_d = beat_q;
    polls_d = polls_q; cap_d = cap_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    sel_d = sel_q; rd_n_d = rd_n_q; wr_n_d = wr_n_q; addr_d = addr_q; wdata_d = wdata_q;
    ax_d = ax_q; ay_d = ay_q; az_d = az_q; sv_d = 1'b0; err_d = err_q;
    advance_s = 1'b0; abort_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i && !err_q) begin
          state_d = S_INIT; step_d = 5'd0; sub_d = 2'd0; beat_d = 2'd0; polls_d = '0; cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (cnt_q >= PERIOD_LAST) begin
          state_d = S_BURST; step_d = BURST_FIRST; sub_d = 2'd0; beat_d = 2'd0; polls_d = '0; cnt_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_INIT, S_BURST, S_RELEASE: begin
        case (beat_q)
          2'd0: begin
            sel_d = 1'b1; rd_n_d = !acc_rd_s; wr_n_d = acc_rd_s;
            addr_d = acc_addr_s; wdata_d = acc_data_s; beat_d = 2'd1;
            if (state_q == S_BURST && step_q == BURST_LAST) begin
              ax_d = {cap_q[1], cap_q[0]}; ay_d = {cap_q[3], cap_q[2]}; az_d = {cap_q[5], cap_q[4]};
              sv_d = 1'b1;
            end else begin
              sv_d = 1'b0;
            end
          end
          2'd1: beat_d = 2'd2;
          default: begin
            sel_d = 1'b0; rd_n_d = 1'b1; wr_n_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;
            beat_d = 2'd0;
            if (state_q == S_RELEASE) begin
              state_d = S_IDLE;
            end else if (op_s == OP_WR) begin
              advance_s = 1'b1;
            end else if (op_s == OP_TMT) begin
              if (spi_rdata_i[5]) begin
                advance_s = 1'b1;
              end else if (polls_q == POLL_MAX) begin
                err_d = 1'b1; abort_s = 1'b1;
              end else begin
                polls_d = polls_q + POLL_W'(1);
              end
            end else begin
              case (sub_q)
                2'd0: begin sub_d = 2'd1; polls_d = '0; end
                2'd1: begin
                  // An overrun/underrun means the captured bytes cannot be trusted: abort too.
                  if (spi_rdata_i[4] || spi_rdata_i[3]) begin
                    err_d = 1'b1; abort_s = 1'b1;
                  end else if (spi_rdata_i[7]) begin
                    sub_d = 2'd2;
                  end else if (polls_q == POLL_MAX) begin
                    err_d = 1'b1; abort_s = 1'b1;
                  end else begin
                    polls_d = polls_q + POLL_W'(1);
                  end
                end
                default: begin
                  advance_s = 1'b1;
                  if (state_q == S_BURST && step_q >= CAP_FIRST && step_q < CAP_FIRST + 5'd6) begin
                    cap_d[cap_idx_s] = rx_byte_s;
`ifdef ACCEL_POLL_DEVID_CHECK_EN
                  end else if (state_q == S_INIT && step_q == 5'd3 && rx_byte_s != 8'hE5) begin
                    err_d = 1'b1; advance_s = 1'b0; abort_s = 1'b1;
`endif
                  end else begin
                    cap_d = cap_q;
                  end
                end
              endcase
            end
          end
        endcase
        if (abort_s) begin
          state_d = S_RELEASE; sub_d = 2'd0; polls_d = '0;
        end else if (advance_s) begin
          sub_d = 2'd0; polls_d = '0;
          if ((state_q == S_INIT && step_q == INIT_LAST) || (state_q == S_BURST && step_q == BURST_LAST)) begin
            state_d = enable_i ? S_WAIT : S_IDLE;
          end else begin
            step_d = step_q + 5'd1;
          end
        end else begin
          step_d = step_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_INIT) || (state_d == S_BURST) || (state_d == S_RELEASE);
  end

  assign spi_select_o   = sel_q;
  assign spi_read_n_o   = rd_n_q;
  assign spi_write_n_o  = wr_n_q;
  assign spi_mem_addr_o = addr_q;
  assign spi_wdata_o    = wdata_q;
  assign accel_x_o      = ax_q;
  assign accel_y_o      = ay_q;
  assign accel_z_o      = az_q;
  assign sample_valid_o = sv_q;
  assign busy_o         = busy_q;
  assign error_o        = err_q;

endmodule
